// File: rtl/timer_counter_pkg.sv
// timer_counter_pkg: shared encodings for the timer/counter block
//   state_t      FSM state encoding (IDLE, LOAD, CNT, INT)
//   ADDR_*       word offsets of CTRL, PRESET and COUNT
//   CTRL_*       bit positions inside CTRL (Enable, Mode, IM)
//   MODE_*       Mode field codes
package timer_counter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_W       = 4;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counter with one-shot / auto-reload modes and a maskable IRQ
//   clk    system clock, all state updates on posedge
//   reset  synchronous active-high reset
//   Addr   word offset: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved
//   WE     write strobe, commits at the posedge where it is high
//   Din    write data
//   DOut   combinational read data for Addr
//   IRQ    irq_flag gated by CTRL.IM
module timer_counter
    import timer_counter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] DOut,
    output logic        IRQ
);

    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       preset;
    logic [31:0]       count;
    logic              irq_flag;
    state_t            state;
    logic              wr_ctrl;
    logic              wr_preset;
    logic              enable;
    logic              reload;

    assign wr_ctrl   = WE && Addr == ADDR_CTRL;
    assign wr_preset = WE && Addr == ADDR_PRESET;
    assign enable    = ctrl[CTRL_EN];
    assign reload    = ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD;
    assign IRQ       = irq_flag & ctrl[CTRL_IM];

    always_comb begin
        DOut = Addr == ADDR_CTRL   ? {{(32-CTRL_W){1'b0}}, ctrl} :
               Addr == ADDR_PRESET ? preset :
               Addr == ADDR_COUNT  ? count  : 32'd0;
    end

    // Later non-blocking assignments win: the FSM's irq_flag set on INT entry
    // is placed after the write-clear so no interrupt is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
            state    <= S_IDLE;
        end else begin
            if (wr_preset)
                preset <= Din;
            if (wr_ctrl)
                ctrl <= Din[CTRL_W-1:0];
            else if (state == S_INT && !reload)
                ctrl[CTRL_EN] <= 1'b0;
            if (wr_ctrl || wr_preset)
                irq_flag <= 1'b0;
            case (state)
                S_IDLE: if (enable) state <= S_LOAD;
                S_LOAD: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else begin
                        count <= preset;
                        state <= S_CNT;
                    end
                end
                S_CNT: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (count != 32'd0) begin
                        count <= count - 32'd1;
                    end else begin
                        state    <= S_INT;
                        irq_flag <= 1'b1;
                    end
                end
                S_INT: begin
                    if (reload) begin
                        state    <= S_LOAD;
                        irq_flag <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: self-checking bench for timer_counter (vector table + scoreboard + corner sequences)
module tb_timer_counter;
    import timer_counter_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] DOut;
    logic        IRQ;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .DOut  (DOut),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        is_irq;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        logic [1:0]  addr;
        logic        we;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    sb_t  sb[$];
    vec_t vt[10];
    int   tests  = 0;
    int   failed = 0;

    // Resolve the oldest outstanding expectation against the live outputs.
    task automatic pop_check();
        sb_t         e;
        logic [31:0] got;
        e   = sb.pop_front();
        got = e.is_irq ? {31'd0, IRQ} : DOut;
        tests++;
        if (got !== e.exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        sb.push_back('{name, 1'b0, d});
        #1;
        pop_check();
    endtask

    task automatic irq_is(input string name, input logic e);
        sb.push_back('{name, 1'b1, {31'd0, e}});
        #1;
        pop_check();
    endtask

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = 2'd0;
        Din   = 32'd0;
        vt[0] = '{ADDR_CTRL,   1'b0, 32'h0,        32'h0,        1'b0};
        vt[1] = '{ADDR_PRESET, 1'b0, 32'h0,        32'h0,        1'b0};
        vt[2] = '{ADDR_COUNT,  1'b0, 32'h0,        32'h0,        1'b0};
        vt[3] = '{2'd3,        1'b0, 32'h0,        32'h0,        1'b0};
        vt[4] = '{ADDR_PRESET, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vt[5] = '{ADDR_CTRL,   1'b1, 32'hFFFFFFF6, 32'h6,        1'b0};
        vt[6] = '{ADDR_COUNT,  1'b1, 32'h1234,     32'h0,        1'b0};
        vt[7] = '{2'd3,        1'b1, 32'h55,       32'h0,        1'b0};
        vt[8] = '{ADDR_PRESET, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
        vt[9] = '{ADDR_CTRL,   1'b1, 32'h0,        32'h0,        1'b0};
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (vt[i].we)
                wr(vt[i].addr, vt[i].din);
            rd($sformatf("vec%0d_dout", i), vt[i].addr, vt[i].exp_dout);
            irq_is($sformatf("vec%0d_irq", i), vt[i].exp_irq);
        end

        // one-shot, PRESET = 3, Enable committed at E0
        wr(ADDR_PRESET, 32'd3);
        wr(ADDR_CTRL, 32'h9);
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            rd($sformatf("os_count_e%0d", k + 2), ADDR_COUNT, 32'd3 - k);
            irq_is($sformatf("os_irq_e%0d", k + 2), 1'b0);
        end
        step();
        irq_is("os_irq_e6", 1'b1);
        rd("os_ctrl_e6", ADDR_CTRL, 32'h9);
        step();
        irq_is("os_irq_e7", 1'b1);
        rd("os_ctrl_e7", ADDR_CTRL, 32'h8);
        repeat (3) step();
        irq_is("os_irq_held", 1'b1);
        wr(ADDR_CTRL, 32'h8);
        irq_is("os_irq_cleared", 1'b0);
        rd("os_ctrl_after_clear", ADDR_CTRL, 32'h8);

        // masked interrupt, PRESET = 1
        wr(ADDR_PRESET, 32'd1);
        wr(ADDR_CTRL, 32'h1);
        for (int c = 1; c <= 6; c++) begin
            step();
            irq_is($sformatf("mask_irq_e%0d", c), 1'b0);
        end
        rd("mask_ctrl_done", ADDR_CTRL, 32'h0);
        wr(ADDR_CTRL, 32'h9);
        irq_is("mask_unmask_cleared", 1'b0);
        for (int c = 1; c <= 4; c++) begin
            step();
            irq_is($sformatf("mask_rerun_e%0d", c), c == 4);
        end
        wr(ADDR_CTRL, 32'h8);
        irq_is("mask_stop", 1'b0);

        // PRESET = 0 gives INT at E3
        wr(ADDR_PRESET, 32'd0);
        wr(ADDR_CTRL, 32'h9);
        for (int c = 1; c <= 3; c++) begin
            step();
            irq_is($sformatf("zero_irq_e%0d", c), c == 3);
        end
        wr(ADDR_CTRL, 32'h8);
        irq_is("zero_stop", 1'b0);

        // auto-reload, PRESET = 2: pulses at E5, E10, E15, ...
        wr(ADDR_PRESET, 32'd2);
        wr(ADDR_CTRL, 32'hB);
        for (int c = 1; c <= 25; c++) begin
            step();
            irq_is($sformatf("ar_irq_e%0d", c), c % 5 == 0);
        end
        wr(ADDR_CTRL, 32'h0);
        irq_is("ar_stop_irq", 1'b0);
        repeat (2) step();
        irq_is("ar_stopped_irq", 1'b0);
        rd("ar_stopped_ctrl", ADDR_CTRL, 32'h0);

        // disable mid-count: CTRL = 0 commits as COUNT steps to 6
        wr(ADDR_PRESET, 32'd10);
        wr(ADDR_CTRL, 32'h9);
        repeat (5) step();
        rd("dis_count7", ADDR_COUNT, 32'd7);
        wr(ADDR_CTRL, 32'h0);
        for (int c = 0; c < 12; c++) begin
            rd($sformatf("dis_hold%0d", c), ADDR_COUNT, 32'd6);
            irq_is($sformatf("dis_irq%0d", c), 1'b0);
            step();
        end

        // PRESET write on the edge that enters INT: set wins
        wr(ADDR_PRESET, 32'd2);
        wr(ADDR_CTRL, 32'h9);
        repeat (4) step();
        rd("sim_count0", ADDR_COUNT, 32'd0);
        irq_is("sim_irq_pre", 1'b0);
        wr(ADDR_PRESET, 32'd7);
        irq_is("sim_set_wins", 1'b1);
        rd("sim_preset", ADDR_PRESET, 32'd7);
        step();
        irq_is("sim_irq_kept", 1'b1);
        rd("sim_ctrl", ADDR_CTRL, 32'h8);
        wr(ADDR_CTRL, 32'h8);
        irq_is("sim_clear", 1'b0);

        // PRESET write during CNT is deferred; reset at COUNT = 4 aborts
        wr(ADDR_PRESET, 32'd10);
        wr(ADDR_CTRL, 32'h9);
        repeat (4) step();
        rd("rst_count8", ADDR_COUNT, 32'd8);
        wr(ADDR_PRESET, 32'd20);
        rd("rst_count_unaffected", ADDR_COUNT, 32'd7);
        repeat (3) step();
        rd("rst_count4", ADDR_COUNT, 32'd4);
        reset = 1'b1;
        Addr  = ADDR_PRESET;
        Din   = 32'h55;
        WE    = 1'b1;
        step();
        WE    = 1'b0;
        rd("rst_ctrl", ADDR_CTRL, 32'h0);
        rd("rst_preset", ADDR_PRESET, 32'h0);
        rd("rst_count", ADDR_COUNT, 32'h0);
        irq_is("rst_irq", 1'b0);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            irq_is($sformatf("rst_post_irq%0d", c), 1'b0);
        end
        rd("rst_post_count", ADDR_COUNT, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Clock and reset SHALL be one clock and a synchronous, active-high reset: clk, reset; no other clock or reset.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Addr  input  2  word offset within the block, taken from bus address bits [3:2]: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
REQ-005 WE  input  1  write strobe; the write commits at the posedge where WE is high.
REQ-006 Din  input  32  write data.
REQ-007 DOut  output  32  combinational read data for the Addr register.
REQ-008 IRQ  output  1  interrupt request; drives one HWInt line of the coprocessor-0 block.

Function
REQ-009 CTRL SHALL be laid out as follows: [0] Enable, [2:1] Mode, [3] IM (interrupt mask); bits [31:4] read 0 and ignore writes.
REQ-010 Mode 00 SHALL be one-shot and Mode 01 SHALL be auto-reload; Modes 10 and 11 SHALL behave as 00.
REQ-011 PRESET SHALL be a 32-bit read/write register; COUNT SHALL be 32-bit read-only, and writes to COUNT or offset 3 SHALL be ignored.
REQ-012 DOut SHALL return CTRL, PRESET or COUNT for Addr 0/1/2 and 0 for Addr 3, in the same cycle.
REQ-013 The FSM SHALL have four states: IDLE, LOAD, CNT, INT.
REQ-014 IDLE SHALL move to LOAD when Enable = 1; otherwise it SHALL stay in IDLE with COUNT held.
REQ-015 LOAD SHALL set COUNT <= PRESET and move to CNT.
REQ-016 CNT SHALL behave as follows: COUNT != 0 -> COUNT <= COUNT - 1, stay in CNT; COUNT == 0 -> move to INT and set irq_flag.
REQ-017 INT in Mode 00 SHALL clear Enable, move to IDLE, and keep irq_flag set.
REQ-018 INT in Mode 01 SHALL move to LOAD and clear irq_flag, giving a one-cycle pulse.
REQ-019 In LOAD or CNT with Enable = 0, the FSM SHALL move to IDLE on the next edge, hold COUNT, and raise no interrupt.
REQ-020 IRQ SHALL equal irq_flag & IM; changing IM SHALL NOT alter irq_flag.
REQ-021 A write to CTRL or PRESET SHALL clear irq_flag, except that setting irq_flag on entry to INT SHALL win over a same-edge write-clear, so no interrupt is lost.
REQ-022 A CTRL write SHALL take priority over the FSM's Enable clear in INT on the same edge.
REQ-023 A PRESET write during CNT SHALL NOT affect the current count; it SHALL take effect at the next LOAD.
REQ-024 Latency: with PRESET = N and the Enable write committing at edge E0, irq_flag SHALL rise at edge E(N+3).
REQ-025 PRESET = 0 SHALL be legal and SHALL give INT at edge E3.
REQ-026 The auto-reload period SHALL be N + 3 cycles from one INT to the next.
REQ-027 COUNT SHALL NOT decrement below 0; there is no wrap-around.

Reset
REQ-028 On reset, CTRL, PRESET, COUNT and irq_flag SHALL be 0, the state SHALL be IDLE, IRQ SHALL be 0, and DOut SHALL reflect the zeroed registers.
REQ-029 Reset mid-count SHALL abort the count with no IRQ pulse; reset SHALL override a simultaneous WE.

Structure
REQ-030 The shared package SHALL hold the state encodings, the Addr offsets for CTRL/PRESET/COUNT, the CTRL bit positions (Enable, Mode, IM), and the Mode codes.
REQ-031 The block SHALL be a single module with no sub-module; the register file and FSM are too small to split.

Verification
REQ-032 The bench SHALL cover reset defaults: assert reset two cycles, then read Addr 0/1/2 -> DOut = 0 for each, IRQ = 0.
REQ-033 The bench SHALL cover one-shot: write PRESET = 3, then CTRL = 0x9 at E0 -> COUNT reads 3, 2, 1, 0 after E2..E5; IRQ rises after E6 and stays high; Enable reads 0 after E7; a CTRL write of 0x8 -> IRQ = 0 on the next cycle.
REQ-034 The bench SHALL cover auto-reload: PRESET = 2, CTRL = 0xB -> one-cycle IRQ pulses exactly 5 cycles apart, at least three pulses observed.
REQ-035 The bench SHALL cover the mask: PRESET = 1, CTRL = 0x1 -> irq_flag sets with IRQ = 0; a later CTRL write of 0x9 -> IRQ stays 0, because the write clears irq_flag.
REQ-036 The bench SHALL cover disable mid-count: PRESET = 10, enable, then write CTRL = 0 when COUNT = 6 -> state IDLE, COUNT holds 6, IRQ never asserts.
REQ-037 The bench SHALL cover simultaneous events: a PRESET write on the same edge the FSM enters INT -> IRQ = 1 (set wins); reset asserted while COUNT = 4 -> all registers 0, no IRQ.
